// File: rtl/bru_bp.sv
// Branch/PC unit: fetch PC register, direct-mapped BTB with 2-bit counters, EX resolve and redirect.
// Optional performance counters are compiled in when BRU_BP_PERF_EN is defined.
module bru_bp #(
   parameter int unsigned     XLEN      = 64,
   parameter logic [XLEN-1:0] RESET_VAL = XLEN'(64'h8000_0000),
   parameter int unsigned     BTB_DEPTH = 16,
   parameter int unsigned     TAG_W     = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_pause,
   input  logic            i_ex_valid,
   input  logic            i_ex_brch,
   input  logic [2:0]      i_ex_func3,
   input  logic            i_ex_jal,
   input  logic            i_ex_jalr,
   input  logic [XLEN-1:0] i_ex_rs1,
   input  logic [XLEN-1:0] i_ex_rs2,
   input  logic [XLEN-1:0] i_ex_imm,
   input  logic [XLEN-1:0] i_ex_pc,
   input  logic [XLEN-1:0] i_ex_pred_pc,
   output logic [XLEN-1:0] o_pc,
   output logic            o_pred_taken,
   output logic [XLEN-1:0] o_pred_pc,
`ifdef BRU_BP_PERF_EN
   output logic [63:0]     o_perf_ctrl,
   output logic [63:0]     o_perf_miss,
`endif
   output logic            o_redirect
);

   localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [TAG_W-1:0] tag_t;

   logic [XLEN-1:0]            pc_q, pc_d;
   logic [BTB_DEPTH-1:0]       btb_vld_q, btb_vld_d;
   logic [BTB_DEPTH-1:0][1:0]  btb_ctr_q, btb_ctr_d;
   tag_t                       btb_tag_q [BTB_DEPTH];
   logic [XLEN-1:0]            btb_tgt_q [BTB_DEPTH];

   idx_t            idx_f, idx_x;
   tag_t            tag_f, tag_x;
   logic            hit_f, hit_x;
   logic            cond, is_ctrl, is_jump, taken, train;
   logic            tgt_we, tag_we;
   logic [XLEN-1:0] jalr_sum, target, actual;

   // Fetch-side lookup
   assign idx_f = pc_q[IDX_W+1:2];
   assign tag_f = pc_q[IDX_W+TAG_W+1:IDX_W+2];
   assign hit_f = btb_vld_q[idx_f] && (btb_tag_q[idx_f] == tag_f);

   assign o_pc         = pc_q;
   assign o_pred_taken = hit_f && btb_ctr_q[idx_f][1];
   assign o_pred_pc    = o_pred_taken ? btb_tgt_q[idx_f] : pc_q + XLEN'(4);

   // EX-side resolve
   assign idx_x = i_ex_pc[IDX_W+1:2];
   assign tag_x = i_ex_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign hit_x = btb_vld_q[idx_x] && (btb_tag_q[idx_x] == tag_x);

   always_comb begin
      // NOTE: default first so every path assigns cond and no latch is inferred.
      cond = 1'b0;
      case (i_ex_func3)
         3'b000:  cond = (i_ex_rs1 == i_ex_rs2);
         3'b001:  cond = (i_ex_rs1 != i_ex_rs2);
         3'b100:  cond = ($signed(i_ex_rs1) <  $signed(i_ex_rs2));
         3'b101:  cond = ($signed(i_ex_rs1) >= $signed(i_ex_rs2));
         3'b110:  cond = (i_ex_rs1 <  i_ex_rs2);
         3'b111:  cond = (i_ex_rs1 >= i_ex_rs2);
         default: cond = 1'b0;
      endcase
   end

   assign is_jump  = i_ex_jal | i_ex_jalr;
   assign is_ctrl  = i_ex_brch | is_jump;
   assign taken    = (i_ex_brch & cond) | is_jump;
   assign jalr_sum = i_ex_rs1 + i_ex_imm;
   assign target   = i_ex_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : i_ex_pc + i_ex_imm;
   assign actual   = taken ? target : i_ex_pc + XLEN'(4);

   // Non-control instructions also redirect when a stale alias predicted them taken.
   assign o_redirect = i_ex_valid && (actual != i_ex_pred_pc);

   assign train  = i_ex_valid && is_ctrl;
   assign tgt_we = train && taken;
   assign tag_we = train && taken && !hit_x;

   always_comb begin
      pc_d = pc_q;
      if (o_redirect) begin
         pc_d = actual;
      end else if (!i_pause) begin
         pc_d = o_pred_pc;
      end
   end

   always_comb begin
      btb_vld_d = btb_vld_q;
      btb_ctr_d = btb_ctr_q;
      if (train) begin
         if (hit_x) begin
            if (is_jump) begin
               btb_ctr_d[idx_x] = 2'd3;
            end else if (taken && btb_ctr_q[idx_x] != 2'd3) begin
               btb_ctr_d[idx_x] = btb_ctr_q[idx_x] + 2'd1;
            end else if (!taken && btb_ctr_q[idx_x] != 2'd0) begin
               btb_ctr_d[idx_x] = btb_ctr_q[idx_x] - 2'd1;
            end
         end else if (taken) begin
            btb_vld_d[idx_x] = 1'b1;
            btb_ctr_d[idx_x] = is_jump ? 2'd3 : 2'd2;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q      <= RESET_VAL;
         btb_vld_q <= '0;
         btb_ctr_q <= '0;
      end else begin
         pc_q      <= pc_d;
         btb_vld_q <= btb_vld_d;
         btb_ctr_q <= btb_ctr_d;
      end
   end

   // NOTE: tag/target storage is not reset; the valid bits guard every read.
   always_ff @(posedge i_clk) begin
      if (tgt_we) begin
         btb_tgt_q[idx_x] <= target;
      end
      if (tag_we) begin
         btb_tag_q[idx_x] <= tag_x;
      end
   end

`ifdef BRU_BP_PERF_EN
   logic [63:0] perf_ctrl_q, perf_ctrl_d;
   logic [63:0] perf_miss_q, perf_miss_d;

   always_comb begin
      perf_ctrl_d = perf_ctrl_q + (train ? 64'd1 : 64'd0);
      perf_miss_d = perf_miss_q + (o_redirect ? 64'd1 : 64'd0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perf_ctrl_q <= '0;
         perf_miss_q <= '0;
      end else begin
         perf_ctrl_q <= perf_ctrl_d;
         perf_miss_q <= perf_miss_d;
      end
   end

   assign o_perf_ctrl = perf_ctrl_q;
   assign o_perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_bru_bp.sv
// Self-checking bench for bru_bp: vector table for resolve logic, hand sequences for BTB training,
// pause/redirect interplay and aliasing; next-PC expectations flow through a scoreboard queue.
module tb_bru_bp;

   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic        clk, rst_n, pause;
   logic        ex_valid, ex_brch, ex_jal, ex_jalr;
   logic [2:0]  ex_func3;
   logic [63:0] ex_rs1, ex_rs2, ex_imm, ex_pc, ex_pred_pc;
   logic [63:0] o_pc, o_pred_pc;
   logic        o_pred_taken, o_redirect;
`ifdef BRU_BP_PERF_EN
   logic [63:0] o_perf_ctrl, o_perf_miss;
`endif

   bru_bp dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_pause      (pause),
      .i_ex_valid   (ex_valid),
      .i_ex_brch    (ex_brch),
      .i_ex_func3   (ex_func3),
      .i_ex_jal     (ex_jal),
      .i_ex_jalr    (ex_jalr),
      .i_ex_rs1     (ex_rs1),
      .i_ex_rs2     (ex_rs2),
      .i_ex_imm     (ex_imm),
      .i_ex_pc      (ex_pc),
      .i_ex_pred_pc (ex_pred_pc),
      .o_pc         (o_pc),
      .o_pred_taken (o_pred_taken),
      .o_pred_pc    (o_pred_pc),
`ifdef BRU_BP_PERF_EN
      .o_perf_ctrl  (o_perf_ctrl),
      .o_perf_miss  (o_perf_miss),
`endif
      .o_redirect   (o_redirect)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        brch;
      logic [2:0]  f3;
      logic        jal;
      logic        jalr;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [63:0] imm;
      logic [63:0] pc;
      logic [63:0] pred;
      logic        exp_redir;
      logic [63:0] exp_pc;
   } vec_t;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [63:0]     exp_q[$];
   longint unsigned ctrl_cnt = 0;
   longint unsigned miss_cnt = 0;
   logic            pred_during;
   vec_t            tbl [14];

   function automatic vec_t mk(input logic valid, input logic brch, input logic [2:0] f3,
                               input logic jal, input logic jalr,
                               input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm,
                               input logic [63:0] pc, input logic [63:0] pred,
                               input logic exp_redir, input logic [63:0] exp_pc);
      vec_t v;
      v.valid = valid; v.brch = brch; v.f3 = f3; v.jal = jal; v.jalr = jalr;
      v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc; v.pred = pred;
      v.exp_redir = exp_redir; v.exp_pc = exp_pc;
      return v;
   endfunction

   function automatic vec_t br(input logic [2:0] f3, input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic [63:0] imm, input logic [63:0] pc, input logic [63:0] pred,
                               input logic exp_redir, input logic [63:0] exp_pc);
      return mk(1'b1, 1'b1, f3, 1'b0, 1'b0, rs1, rs2, imm, pc, pred, exp_redir, exp_pc);
   endfunction

   // Non-control instruction; used to steer o_pc to a chosen address without training.
   function automatic vec_t nc(input logic [63:0] pc, input logic [63:0] pred,
                               input logic exp_redir, input logic [63:0] exp_pc);
      return mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, pc, pred, exp_redir, exp_pc);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s pc: scoreboard empty, got %h", name, o_pc);
      end else begin
         check({name, " pc"}, o_pc, exp_q.pop_front());
      end
   endtask

   // Called at posedge+1; drives one EX slot, checks redirect mid-cycle, checks o_pc after the edge.
   task automatic ex_cycle(input vec_t v, input string name);
      ex_valid   = v.valid;
      ex_brch    = v.brch;
      ex_func3   = v.f3;
      ex_jal     = v.jal;
      ex_jalr    = v.jalr;
      ex_rs1     = v.rs1;
      ex_rs2     = v.rs2;
      ex_imm     = v.imm;
      ex_pc      = v.pc;
      ex_pred_pc = v.pred;
      #4;
      pred_during = o_pred_taken;
      check({name, " redirect"}, 64'(o_redirect), 64'(v.exp_redir));
      exp_q.push_back(v.exp_pc);
      if (v.valid && (v.brch || v.jal || v.jalr)) ctrl_cnt++;
      if (v.exp_redir) miss_cnt++;
      @(posedge clk);
      #1;
      ex_valid = 1'b0;
      pop_check(name);
   endtask

   task automatic idle_cycle(input logic [63:0] exp_pc, input string name);
      ex_valid = 1'b0;
      exp_q.push_back(exp_pc);
      @(posedge clk);
      #1;
      pop_check(name);
   endtask

   task automatic check_pred(input string name, input logic exp_taken, input logic [63:0] exp_pc);
      check({name, " pred_taken"}, 64'(o_pred_taken), 64'(exp_taken));
      check({name, " pred_pc"}, o_pred_pc, exp_pc);
   endtask

   initial begin
      // Resolve-logic vectors, applied with fetch paused so o_pc only moves on redirect.
      tbl[0]  = br(3'b000, 64'd5, 64'd5, 64'h20, 64'h8000_0200, 64'h8000_0204, 1'b1, 64'h8000_0220);
      tbl[1]  = br(3'b000, 64'd5, 64'd6, 64'h20, 64'h8000_0200, 64'h8000_0204, 1'b0, 64'h8000_0220);
      tbl[2]  = br(3'b001, 64'd5, 64'd6, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8000_0200, 64'h8000_0204, 1'b1, 64'h8000_01F8);
      tbl[3]  = br(3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h8000_0204, 64'h8000_0244, 1'b0, 64'h8000_01F8);
      tbl[4]  = br(3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 64'h8000_0208, 64'h8000_0248, 1'b1, 64'h8000_020C);
      tbl[5]  = br(3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 64'h8000_0210, 64'h8000_0214, 1'b0, 64'h8000_020C);
      tbl[6]  = br(3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h10, 64'h8000_0210, 64'h8000_0214, 1'b1, 64'h8000_0220);
      tbl[7]  = br(3'b101, 64'd7, 64'd7, 64'h8, 64'h8000_0218, 64'h8000_0220, 1'b0, 64'h8000_0220);
      tbl[8]  = br(3'b010, 64'd0, 64'd0, 64'h8, 64'h8000_021C, 64'h8000_0220, 1'b0, 64'h8000_0220);
      tbl[9]  = nc(64'h8000_0224, 64'h8000_0300, 1'b1, 64'h8000_0228);
      tbl[10] = mk(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 64'd0, 64'd0, 64'h100,
                   64'h8000_0228, 64'h8000_022C, 1'b1, 64'h8000_0328);
      tbl[11] = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 64'h8000_1001, 64'd0, 64'h4,
                   64'h8000_0230, 64'h8000_1004, 1'b0, 64'h8000_0328);
      tbl[12] = mk(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 64'd0, 64'd0, 64'h20,
                   64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 1'b1, 64'h10);
      tbl[13] = mk(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 64'd1, 64'd1, 64'h20,
                   64'h8000_0000, 64'h0, 1'b0, 64'h10);

      rst_n = 1'b0; pause = 1'b0; ex_valid = 1'b0; ex_brch = 1'b0; ex_func3 = 3'b000;
      ex_jal = 1'b0; ex_jalr = 1'b0; ex_rs1 = '0; ex_rs2 = '0; ex_imm = '0; ex_pc = '0; ex_pred_pc = '0;

      // Reset and free-running sequential fetch
      repeat (3) @(posedge clk);
      #1;
      check("reset pc", o_pc, RST_PC);
      check_pred("reset", 1'b0, 64'h8000_0004);
`ifdef BRU_BP_PERF_EN
      check("reset perf_ctrl", o_perf_ctrl, 64'd0);
      check("reset perf_miss", o_perf_miss, 64'd0);
`endif
      rst_n = 1'b1;
      idle_cycle(64'h8000_0004, "seq1");
      idle_cycle(64'h8000_0008, "seq2");
      pause = 1'b1;
      idle_cycle(64'h8000_0008, "pause1");
      idle_cycle(64'h8000_0008, "pause2");

      for (int i = 0; i < 14; i++) begin
         ex_cycle(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset mid-operation: PC and all trained BTB state must be gone
      rst_n = 1'b0;
      #1;
      check("midreset pc", o_pc, RST_PC);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      ctrl_cnt = 0;
      miss_cnt = 0;
      ex_cycle(nc(64'h8000_01FC, 64'h0, 1'b1, 64'h8000_0200), "post_reset_steer");
      check_pred("post_reset", 1'b0, 64'h8000_0204);

      // BEQ cold miss, then refetch hits
      ex_cycle(br(3'b000, 64'd5, 64'd5, 64'h20, 64'h8000_0010, 64'h8000_0014, 1'b1, 64'h8000_0030), "beq_cold");
      ex_cycle(nc(64'h8000_000C, 64'h0, 1'b1, 64'h8000_0010), "refetch_a");
      check_pred("beq_hit", 1'b1, 64'h8000_0030);

      // BLTU not-taken training; the first one trains while o_pc looks up the same entry
      ex_cycle(br(3'b110, 64'd5, 64'd3, 64'h20, 64'h8000_0010, 64'h8000_0030, 1'b1, 64'h8000_0014), "bltu_nt1");
      check("same_cycle pred_taken", 64'(pred_during), 64'd1);
      ex_cycle(nc(64'h8000_000C, 64'h0, 1'b1, 64'h8000_0010), "refetch_b");
      check_pred("ctr1", 1'b0, 64'h8000_0014);
      ex_cycle(br(3'b110, 64'd5, 64'd3, 64'h20, 64'h8000_0010, 64'h8000_0014, 1'b0, 64'h8000_0010), "bltu_nt2");
      check_pred("ctr0", 1'b0, 64'h8000_0014);
      ex_cycle(br(3'b110, 64'd5, 64'd3, 64'h20, 64'h8000_0010, 64'h8000_0014, 1'b0, 64'h8000_0010), "bltu_nt3");
      ex_cycle(br(3'b110, 64'd3, 64'd5, 64'h20, 64'h8000_0010, 64'h8000_0014, 1'b1, 64'h8000_0030), "bltu_t");
      ex_cycle(nc(64'h8000_000C, 64'h0, 1'b1, 64'h8000_0010), "refetch_c");
      check_pred("ctr_sat0", 1'b0, 64'h8000_0014);

      // JALR allocation with ctr=3, correctly predicted repeat, then one not-taken keeps it taken
      ex_cycle(mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 64'h8000_1001, 64'd0, 64'h4,
                  64'h8000_0040, 64'h8000_0044, 1'b1, 64'h8000_1004), "jalr_cold");
      ex_cycle(nc(64'h8000_003C, 64'h0, 1'b1, 64'h8000_0040), "refetch_d");
      check_pred("jalr_hit", 1'b1, 64'h8000_1004);
      ex_cycle(mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 64'h8000_1001, 64'd0, 64'h4,
                  64'h8000_0040, 64'h8000_1004, 1'b0, 64'h8000_0040), "jalr_ok");
      ex_cycle(br(3'b000, 64'd1, 64'd2, 64'h20, 64'h8000_0040, 64'h8000_1004, 1'b1, 64'h8000_0044), "ctr3_dec");
      ex_cycle(nc(64'h8000_003C, 64'h0, 1'b1, 64'h8000_0040), "refetch_e");
      check_pred("ctr2_after3", 1'b1, 64'h8000_1004);

      // Unpaused fetch follows the prediction, then pause holds, then redirect overrides pause
      pause = 1'b0;
      idle_cycle(64'h8000_1004, "follow_pred");
      idle_cycle(64'h8000_1008, "follow_seq");
      pause = 1'b1;
      idle_cycle(64'h8000_1008, "hold1");
      idle_cycle(64'h8000_1008, "hold2");
      ex_cycle(nc(64'h8000_1008, 64'h8000_1010, 1'b1, 64'h8000_100C), "pause_redirect");

      // Aliasing: same index, different tags, alternating taken branches
      ex_cycle(br(3'b000, 64'd0, 64'd0, 64'h40, 64'h8000_0020, 64'h8000_0024, 1'b1, 64'h8000_0060), "alias_a1");
      ex_cycle(br(3'b000, 64'd0, 64'd0, 64'h40, 64'h8000_0420, 64'h8000_0424, 1'b1, 64'h8000_0460), "alias_b1");
      ex_cycle(br(3'b000, 64'd0, 64'd0, 64'h40, 64'h8000_0020, 64'h8000_0024, 1'b1, 64'h8000_0060), "alias_a2");
      ex_cycle(br(3'b000, 64'd0, 64'd0, 64'h40, 64'h8000_0420, 64'h8000_0424, 1'b1, 64'h8000_0460), "alias_b2");
      ex_cycle(nc(64'h8000_001C, 64'h0, 1'b1, 64'h8000_0020), "refetch_f");
      check_pred("alias_miss", 1'b0, 64'h8000_0024);

`ifdef BRU_BP_PERF_EN
      check("perf_ctrl", o_perf_ctrl, 64'(ctrl_cnt));
      check("perf_miss", o_perf_miss, 64'(miss_cnt));
`endif
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL scoreboard drain: %0d entries left", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bru_bp.md
Name: bru_bp

Overview:
- Next-generation branch/PC unit: owns the fetch PC register and predicts the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Resolves branches, JAL and JALR in EX, redirects fetch on mispredict, and trains the BTB.
- Sits between IFU (consumes o_pc, o_pred_*) and EXU (drives i_ex_*).

Parameters:
XLEN, 64, datapath/PC width
RESET_VAL, 64'h80000000, PC value after reset
BTB_DEPTH, 16, BTB entries; power of 2, >= 2
TAG_W, 8, tag bits stored per entry

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_pause  in  1  hold fetch PC (ignored when redirecting)
i_ex_valid  in  1  EX instruction valid; one pulse per instruction
i_ex_brch  in  1  EX instruction is a conditional branch
i_ex_func3  in  3  branch func3
i_ex_jal  in  1  EX instruction is JAL
i_ex_jalr  in  1  EX instruction is JALR
i_ex_rs1  in  XLEN  rs1 value
i_ex_rs2  in  XLEN  rs2 value
i_ex_imm  in  XLEN  sign-extended immediate
i_ex_pc  in  XLEN  PC of EX instruction
i_ex_pred_pc  in  XLEN  next-PC predicted when that instruction was fetched
o_pc  out  XLEN  current fetch PC
o_pred_taken  out  1  prediction for o_pc is taken
o_pred_pc  out  XLEN  predicted next PC for o_pc
o_redirect  out  1  mispredict: flush younger instructions

Behaviour:
- Reset (async, i_rst_n=0): o_pc=RESET_VAL; all BTB valid bits and counters cleared to 0. Reset mid-operation discards all in-flight training.
- Index = pc[log2(BTB_DEPTH)+1:2]; tag = pc[log2(BTB_DEPTH)+TAG_W+1 : log2(BTB_DEPTH)+2].
- Predict (combinational from o_pc): hit = valid & tag match. o_pred_taken = hit & ctr[1]. o_pred_pc = o_pred_taken ? entry.target : o_pc+4.
- Resolve (combinational, only when i_ex_valid):
  - Compare func3 codes: 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. Any other code is not-taken.
  - taken = (i_ex_brch & cond) | i_ex_jal | i_ex_jalr.
  - target = i_ex_jalr ? ((rs1+imm) & ~1) : (i_ex_pc+imm). All arithmetic is XLEN-bit and wraps.
  - actual = taken ? target : i_ex_pc+4.
  - o_redirect = i_ex_valid & (actual != i_ex_pred_pc). Non-control instructions with a wrong prediction (stale alias) also redirect.
- PC update on the clock edge:
  - o_redirect: o_pc <= actual. Overrides i_pause.
  - else if !i_pause: o_pc <= o_pred_pc.
  - else hold.
  - Redirect latency is 1 cycle: the corrected PC appears on o_pc the cycle after o_redirect.
- Training (clock edge, i_ex_valid & (brch|jal|jalr)), EX index/tag:
  - Hit: target <= target (only if taken); counter saturating +1 if taken, -1 if not. JAL/JALR force ctr=3.
  - Miss and taken: allocate/overwrite entry: valid=1, tag, target, ctr=2 (JAL/JALR: 3).
  - Miss and not taken: no write.
- Same-cycle predict and train on the same index: prediction uses the pre-write contents; the new contents are visible the next cycle.
- Counter saturates at 0 and 3; no wrap.

Optional Feature:
- Macro BRU_BP_PERF_EN.
- Defined: adds outputs o_perf_ctrl (64b, count of i_ex_valid control instructions) and o_perf_miss (64b, count of o_redirect cycles). Both reset to 0 and wrap at 2^64.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset: i_rst_n low then high, no EX activity, i_pause=0 -> o_pc sequence 0x80000000, 0x80000004, 0x80000008; o_pred_taken=0.
- BEQ cold miss: EX valid, pc=0x80000010, rs1=rs2=5, imm=0x20, pred_pc=0x80000014 -> o_redirect=1; next o_pc=0x80000030; entry allocated with ctr=2. Refetch of 0x80000010 -> o_pred_taken=1, o_pred_pc=0x80000030.
- Counter training: the same BLTU resolved not-taken twice (rs1=5, rs2=3) -> ctr 2->1->0; from then on 0x80000010 predicts 0x80000014 and correctly predicted not-taken resolutions give o_redirect=0.
- JALR: rs1=0x80001001, imm=4 -> target 0x80001004 (LSB cleared), ctr=3; a later JALR whose prediction matches -> no redirect.
- Pause vs redirect: i_pause=1 held with no mispredict -> o_pc stable. i_pause=1 together with a mispredict -> o_pc loads the corrected PC next cycle.
- Aliasing: two taken branches with the same index and different tags, resolved alternately -> each miss reallocates the entry and redirects. With BRU_BP_PERF_EN, o_perf_miss equals the number of redirect cycles.
